bbpll_bringup_seq: RTL and testbench

- Power-up and lock-acquisition sequencer for the bang-bang PLL.
- Drives the PLL's sleep, reset, frequency/phase-acquisition and pseudo-random dither enables from a single start command.
- Qualifies the PLL `locked` flag over a hold window, retries on timeout and reports final status.
- Sits between the configuration register block and the PLL top; runs entirely in the reference clock domain.

---
 rtl/bbpll_seq_pkg.sv | 85 ++++++++
 rtl/bbpll_seq_timer.sv | 39 +++
 rtl/bbpll_bringup_seq.sv | 199 +++++++++++++++++++
 tb/tb_bbpll_bringup_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbpll_seq_pkg.sv
// Shared types for the bang-bang PLL bring-up sequencer: state encoding,
// default widths and the registered-output bundle with its state decoder.
package bbpll_seq_pkg;

  localparam int TIMER_BITS_DEFAULT = 16;
  localparam int HOLD_BITS_DEFAULT  = 10;
  localparam int RETRY_BITS_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAKE   = 3'd1,
    FREQ   = 3'd2,
    PHASE  = 3'd3,
    RETRY  = 3'd4,
    LOCKED = 3'd5,
    FAIL   = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic       pll_reset;
    logic       sleep_b;
    logic       freq_acq;
    logic       phase_acq;
    logic       prnd;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [2:0] state;
  } seq_out_t;

  localparam seq_out_t OUT_RESET = '{
    pll_reset: 1'b1, sleep_b: 1'b0, freq_acq: 1'b0, phase_acq: 1'b0,
    prnd: 1'b0, busy: 1'b0, locked: 1'b0, fail: 1'b0, state: 3'd0
  };

  // Pure decode of the PLL control pins for a given state; dither follows its
  // configuration bit live while locked.
  function automatic seq_out_t decode_state(input seq_state_t s, input logic dither);
    seq_out_t o;
    o       = '0;
    o.state = s;
    case (s)
      IDLE: begin
        o.pll_reset = 1'b1;
      end
      WAKE: begin
        o.pll_reset = 1'b1;
        o.sleep_b   = 1'b1;
        o.busy      = 1'b1;
      end
      FREQ: begin
        o.sleep_b   = 1'b1;
        o.freq_acq  = 1'b1;
        o.busy      = 1'b1;
      end
      PHASE: begin
        o.sleep_b   = 1'b1;
        o.freq_acq  = 1'b1;
        o.phase_acq = 1'b1;
        o.busy      = 1'b1;
      end
      RETRY: begin
        o.pll_reset = 1'b1;
        o.sleep_b   = 1'b1;
        o.busy      = 1'b1;
      end
      LOCKED: begin
        o.sleep_b   = 1'b1;
        o.freq_acq  = 1'b1;
        o.phase_acq = 1'b1;
        o.prnd      = dither;
        o.locked    = 1'b1;
      end
      FAIL: begin
        o.pll_reset = 1'b1;
        o.fail      = 1'b1;
      end
      default: begin
        o.pll_reset = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bbpll_seq_timer.sv
// Loadable down-counter for the sequencer's timed states. A load of N gives N
// cycles before expiry; N=0 is treated as 1.
module bbpll_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Load N-1 so the state sees expired on its Nth cycle.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = (load_value == '0) ? '0 : load_value - WIDTH'(1);
    end else if (count_reg != '0) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/bbpll_bringup_seq.sv
// Power-up and lock-acquisition sequencer for the bang-bang PLL.
// Optional automatic relock from LOCKED is enabled by BBPLL_SEQ_AUTO_RELOCK_EN.
module bbpll_bringup_seq
  import bbpll_seq_pkg::*;
#(
  parameter int TIMER_BITS = TIMER_BITS_DEFAULT,
  parameter int HOLD_BITS  = HOLD_BITS_DEFAULT,
  parameter int RETRY_BITS = RETRY_BITS_DEFAULT
) (
  input  logic                  referenceClock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TIMER_BITS-1:0] wakeCycles,
  input  logic [TIMER_BITS-1:0] freqCycles,
  input  logic [TIMER_BITS-1:0] acqTimeout,
  input  logic [HOLD_BITS-1:0]  lockHoldCycles,
  input  logic [RETRY_BITS-1:0] maxRetries,
  input  logic                  ditherCfg,
  input  logic                  pllLocked,
  output logic                  pllReset,
  output logic                  pllSleepB,
  output logic                  freqAcqEnable,
  output logic                  phaseAcqEnable,
  output logic                  prndGenEnable,
  output logic                  prndDitEnable,
  output logic                  busy,
  output logic                  seqLocked,
  output logic                  seqFail,
  output logic                  lockLost,
  output logic [RETRY_BITS-1:0] retryCount,
  output logic [2:0]            seqState
);

  seq_state_t            state_reg, state_next;
  logic [HOLD_BITS-1:0]  hold_reg, hold_next;
  logic [RETRY_BITS-1:0] retry_reg, retry_next;
  logic                  lock_lost_reg, lock_lost_next;
  seq_out_t              out_reg, out_next;

  logic                  timer_clear;
  logic                  timer_load;
  logic [TIMER_BITS-1:0] timer_value;
  logic                  timer_expired;

  logic [HOLD_BITS-1:0]  hold_target;
  logic [HOLD_BITS-1:0]  hold_inc;

`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
  logic [HOLD_BITS-1:0]  los_reg, los_next;
  logic [HOLD_BITS-1:0]  los_inc;
  assign los_inc = (los_reg == '1) ? los_reg : los_reg + HOLD_BITS'(1);
`endif

  assign hold_target = (lockHoldCycles == '0) ? HOLD_BITS'(1) : lockHoldCycles;
  assign hold_inc    = (hold_reg == '1) ? hold_reg : hold_reg + HOLD_BITS'(1);

  bbpll_seq_timer #(
    .WIDTH(TIMER_BITS)
  ) u_timer (
    .clk        (referenceClock),
    .rst        (reset),
    .clear      (timer_clear),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      retry_reg     <= '0;
      lock_lost_reg <= 1'b0;
`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
      los_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      retry_reg     <= retry_next;
      lock_lost_reg <= lock_lost_next;
`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
      los_reg       <= los_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    retry_next     = retry_reg;
    lock_lost_next = lock_lost_reg;
    timer_clear    = 1'b0;
    timer_load     = 1'b0;
    timer_value    = wakeCycles;
`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
    los_next       = '0;
`endif
    if (abort) begin
      state_next     = IDLE;
      hold_next      = '0;
      retry_next     = '0;
      lock_lost_next = 1'b0;
      timer_clear    = 1'b1;
    end else begin
      case (state_reg)
        IDLE, FAIL: begin
          if (start) begin
            state_next     = WAKE;
            timer_load     = 1'b1;
            timer_value    = wakeCycles;
            retry_next     = '0;
            lock_lost_next = 1'b0;
          end
        end
        WAKE: begin
          if (timer_expired) begin
            state_next  = FREQ;
            timer_load  = 1'b1;
            timer_value = freqCycles;
          end
        end
        FREQ: begin
          if (timer_expired) begin
            state_next  = PHASE;
            timer_load  = 1'b1;
            timer_value = acqTimeout;
            hold_next   = '0;
          end
        end
        PHASE: begin
          hold_next = pllLocked ? hold_inc : '0;
          // Qualification is checked first so a lock on the last budget cycle still counts.
          if (pllLocked && (hold_inc >= hold_target)) begin
            state_next = LOCKED;
          end else if (timer_expired) begin
            state_next = RETRY;
          end
        end
        RETRY: begin
          if (retry_reg >= maxRetries) begin
            state_next = FAIL;
          end else begin
            state_next  = WAKE;
            retry_next  = retry_reg + RETRY_BITS'(1);
            timer_load  = 1'b1;
            timer_value = wakeCycles;
          end
        end
        LOCKED: begin
          if (!pllLocked) begin
            lock_lost_next = 1'b1;
          end
`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
          los_next = pllLocked ? '0 : los_inc;
          if (!pllLocked && (los_inc >= hold_target)) begin
            state_next  = PHASE;
            timer_load  = 1'b1;
            timer_value = acqTimeout;
            hold_next   = '0;
            los_next    = '0;
          end
`endif
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_next = decode_state(state_reg, ditherCfg);
  end

  // Control pins are a registered decode of the current state, one cycle behind it.
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      out_reg <= OUT_RESET;
    end else begin
      out_reg <= out_next;
    end
  end

  assign pllReset       = out_reg.pll_reset;
  assign pllSleepB      = out_reg.sleep_b;
  assign freqAcqEnable  = out_reg.freq_acq;
  assign phaseAcqEnable = out_reg.phase_acq;
  assign prndGenEnable  = out_reg.prnd;
  assign prndDitEnable  = out_reg.prnd;
  assign busy           = out_reg.busy;
  assign seqLocked      = out_reg.locked;
  assign seqFail        = out_reg.fail;
  assign seqState       = out_reg.state;
  assign lockLost       = lock_lost_reg;
  assign retryCount     = retry_reg;

endmodule

// File: tb/tb_bbpll_bringup_seq.sv
// Self-checking bench for bbpll_bringup_seq: table of full bring-up runs with a
// scoreboard of expected completion timing, plus hand-written corner sequences.
module tb_bbpll_bringup_seq;

  logic        referenceClock = 1'b0;
  logic        reset          = 1'b1;
  logic        start          = 1'b0;
  logic        abort          = 1'b0;
  logic [15:0] wakeCycles     = '0;
  logic [15:0] freqCycles     = '0;
  logic [15:0] acqTimeout     = '0;
  logic [9:0]  lockHoldCycles = '0;
  logic [2:0]  maxRetries     = '0;
  logic        ditherCfg      = 1'b0;
  logic        pllLocked      = 1'b0;

  logic        pllReset, pllSleepB, freqAcqEnable, phaseAcqEnable;
  logic        prndGenEnable, prndDitEnable, busy, seqLocked, seqFail, lockLost;
  logic [2:0]  retryCount;
  logic [2:0]  seqState;

  int tests = 0;
  int fails = 0;

  always #5 referenceClock = ~referenceClock;

  bbpll_bringup_seq dut (
    .referenceClock (referenceClock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .wakeCycles     (wakeCycles),
    .freqCycles     (freqCycles),
    .acqTimeout     (acqTimeout),
    .lockHoldCycles (lockHoldCycles),
    .maxRetries     (maxRetries),
    .ditherCfg      (ditherCfg),
    .pllLocked      (pllLocked),
    .pllReset       (pllReset),
    .pllSleepB      (pllSleepB),
    .freqAcqEnable  (freqAcqEnable),
    .phaseAcqEnable (phaseAcqEnable),
    .prndGenEnable  (prndGenEnable),
    .prndDitEnable  (prndDitEnable),
    .busy           (busy),
    .seqLocked      (seqLocked),
    .seqFail        (seqFail),
    .lockLost       (lockLost),
    .retryCount     (retryCount),
    .seqState       (seqState)
  );

  // Stimulus plus expected timing, in cycles counted from the edge that accepts start.
  // lock_at: PHASE cycle where pllLocked first samples high (0 = never);
  // glitch: offset from lock_at of a single low cycle (0 = none).
  typedef struct {
    int wake, freq, tmo, hold, retries, lock_at, glitch;
    int exp_cycles, exp_retry, exp_fail, exp_rst_fall, exp_phase_rise;
  } vec_t;

  typedef struct {
    int cycles, retry, fail, rst_fall, phase_rise;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int max1(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic return_to_idle();
    abort     = 1'b1;
    pllLocked = 1'b0;
    @(negedge referenceClock);
    abort = 1'b0;
    @(negedge referenceClock);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, got;
    int   n, base, sleep_rise;
    bit   done;
    e.cycles     = v.exp_cycles;
    e.retry      = v.exp_retry;
    e.fail       = v.exp_fail;
    e.rst_fall   = v.exp_rst_fall;
    e.phase_rise = v.exp_phase_rise;
    sb.push_back(e);
    wakeCycles     = 16'(v.wake);
    freqCycles     = 16'(v.freq);
    acqTimeout     = 16'(v.tmo);
    lockHoldCycles = 10'(v.hold);
    maxRetries     = 3'(v.retries);
    ditherCfg      = 1'b0;
    pllLocked      = 1'b0;
    base = max1(v.wake) + max1(v.freq) + v.lock_at;
    start = 1'b1;
    @(negedge referenceClock);
    start = 1'b0;
    n = 0; done = 0; sleep_rise = -1; got.rst_fall = -1; got.phase_rise = -1;
    for (int c = 0; c < 400 && !done; c++) begin
      if (sleep_rise < 0 && pllSleepB) sleep_rise = n;
      if (got.rst_fall < 0 && !pllReset) got.rst_fall = n;
      if (got.phase_rise < 0 && phaseAcqEnable) got.phase_rise = n;
      if (seqLocked || seqFail) begin
        done = 1;
      end else begin
        pllLocked = (v.lock_at > 0) && (n + 1 >= base) &&
                    !(v.glitch > 0 && n + 1 == base + v.glitch);
        @(negedge referenceClock);
        n++;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL vec%0d_done: no seqLocked/seqFail within 400 cycles", idx);
    end else begin
      $display("[TB] vec %0d: finished after %0d cycles, retryCount=%0d, seqFail=%0d",
               idx, n, retryCount, seqFail);
      check($sformatf("vec%0d_cycles", idx), n, e.cycles);
      check($sformatf("vec%0d_retry", idx), int'(retryCount), e.retry);
      check($sformatf("vec%0d_fail", idx), int'(seqFail), e.fail);
      check($sformatf("vec%0d_locked", idx), int'(seqLocked), 1 - e.fail);
      check($sformatf("vec%0d_state", idx), int'(seqState), e.fail ? 6 : 5);
      check($sformatf("vec%0d_sleep_rise", idx), sleep_rise, 1);
      check($sformatf("vec%0d_rst_fall", idx), got.rst_fall, e.rst_fall);
      check($sformatf("vec%0d_phase_rise", idx), got.phase_rise, e.phase_rise);
      if (e.fail != 0) begin
        check($sformatf("vec%0d_fail_rst", idx), int'(pllReset), 1);
        check($sformatf("vec%0d_fail_sleep", idx), int'(pllSleepB), 0);
      end
    end
    return_to_idle();
  endtask

  task automatic wait_for(input string name, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      case (name)
        "locked": ok = seqLocked;
        "freq_r1": ok = (retryCount == 3'd1) && freqAcqEnable && !phaseAcqEnable;
        default:  ok = phaseAcqEnable;
      endcase
      if (!ok) @(negedge referenceClock);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{4, 8, 100, 5, 0, 10, 0, 27, 0, 0, 5, 13};
    vecs[1] = '{0, 0, 5, 0, 0, 1, 0, 4, 0, 0, 2, 3};
    vecs[2] = '{4, 8, 20, 5, 2, 0, 0, 100, 2, 1, 5, 13};
    vecs[3] = '{2, 3, 50, 5, 0, 2, 3, 16, 0, 0, 3, 6};
    vecs[4] = '{3, 2, 10, 5, 1, 6, 0, 16, 0, 0, 4, 6};
    vecs[5] = '{1, 1, 1, 5, 3, 0, 0, 17, 3, 1, 2, 3};
    vecs[6] = '{2, 2, 3, 5, 0, 0, 0, 9, 0, 1, 3, 5};

    // Reset state
    @(negedge referenceClock);
    check("rst_pllReset", int'(pllReset), 1);
    check("rst_sleepB", int'(pllSleepB), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(seqState), 0);
    check("rst_retry", int'(retryCount), 0);
    check("rst_lockLost", int'(lockLost), 0);
    reset = 1'b0;
    @(negedge referenceClock);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // LOCKED with dither, then a 3+ cycle loss of lock
    wakeCycles = 16'd1; freqCycles = 16'd1; acqTimeout = 16'd50;
    lockHoldCycles = 10'd3; maxRetries = 3'd0; ditherCfg = 1'b1; pllLocked = 1'b1;
    start = 1'b1;
    @(negedge referenceClock);
    start = 1'b0;
    wait_for("locked", 50, ok);
    $display("[TB] dither run: locked=%0d prndGen=%0d", seqLocked, prndGenEnable);
    check("dither_gen_on", int'(prndGenEnable), 1);
    check("dither_dit_on", int'(prndDitEnable), 1);
    ditherCfg = 1'b0;
    @(negedge referenceClock);
    check("dither_gen_track", int'(prndGenEnable), 0);
    ditherCfg = 1'b1;
    @(negedge referenceClock);
    check("dither_gen_back", int'(prndGenEnable), 1);
    pllLocked = 1'b0;
    repeat (4) @(negedge referenceClock);
    check("loss_lockLost", int'(lockLost), 1);
`ifdef BBPLL_SEQ_AUTO_RELOCK_EN
    check("loss_state", int'(seqState), 3);
    check("loss_prndGen", int'(prndGenEnable), 0);
    check("loss_prndDit", int'(prndDitEnable), 0);
    check("loss_seqLocked", int'(seqLocked), 0);
`else
    check("loss_state", int'(seqState), 5);
    check("loss_prndGen", int'(prndGenEnable), 1);
    check("loss_seqLocked", int'(seqLocked), 1);
`endif
    pllLocked = 1'b1;
    @(negedge referenceClock);
    check("loss_sticky", int'(lockLost), 1);
    abort = 1'b1;
    @(negedge referenceClock);
    abort = 1'b0;
    check("abort_clears_lockLost", int'(lockLost), 0);
    return_to_idle();

    // abort together with start while in FREQ, after one retry
    wakeCycles = 16'd2; freqCycles = 16'd20; acqTimeout = 16'd1;
    lockHoldCycles = 10'd5; maxRetries = 3'd3; ditherCfg = 1'b0; pllLocked = 1'b0;
    start = 1'b1;
    @(negedge referenceClock);
    start = 1'b0;
    wait_for("freq_r1", 100, ok);
    abort = 1'b1; start = 1'b1;
    @(negedge referenceClock);
    abort = 1'b0; start = 1'b0;
    @(negedge referenceClock);
    $display("[TB] abort in FREQ: state=%0d pllReset=%0d retryCount=%0d", seqState, pllReset, retryCount);
    check("abort_state", int'(seqState), 0);
    check("abort_pllReset", int'(pllReset), 1);
    check("abort_sleepB", int'(pllSleepB), 0);
    check("abort_freq", int'(freqAcqEnable), 0);
    check("abort_phase", int'(phaseAcqEnable), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_retry", int'(retryCount), 0);
    repeat (3) @(negedge referenceClock);
    check("abort_start_ignored", int'(seqState), 0);
    check("abort_sleep_stays", int'(pllSleepB), 0);

    // asynchronous reset pulse between edges while in PHASE
    wakeCycles = 16'd2; freqCycles = 16'd2; acqTimeout = 16'd200; maxRetries = 3'd0;
    start = 1'b1;
    @(negedge referenceClock);
    start = 1'b0;
    wait_for("phase", 20, ok);
    #2 reset = 1'b1;
    #1;
    $display("[TB] async reset mid-PHASE: pllReset=%0d state=%0d", pllReset, seqState);
    check("areset_pllReset", int'(pllReset), 1);
    check("areset_phase", int'(phaseAcqEnable), 0);
    check("areset_freq", int'(freqAcqEnable), 0);
    check("areset_sleepB", int'(pllSleepB), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_state", int'(seqState), 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge referenceClock);
    check("areset_stays_idle", int'(seqState), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
